// File: rtl/modinv_fermat_4049.sv
// rtl/modinv_fermat_4049.sv - modular inverse mod 4049 by Fermat square-and-multiply
// One Barrett modmul per clock; result is held until the consumer takes it.
module modinv_fermat_4049 #(
    parameter int unsigned W   = 12,
    parameter int unsigned Q   = 4049,
    parameter int unsigned MU  = 4143,
    parameter int unsigned EXP = 4047
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_a,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] dout_r,
    output logic         zero_err,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int unsigned IW = $clog2(W);
    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0]   Q_W   = W'(Q);
    localparam logic [W+1:0]   Q_R   = (W + 2)'(Q);
    localparam logic [W:0]     MU_W  = (W + 1)'(MU);
    localparam logic [W-1:0]   EXP_W = W'(EXP);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    acc;
    logic [W-1:0]    base;
    logic [IW-1:0]   idx;
    logic            zero_q;

    logic [W-1:0]    base_in;
    logic [W-1:0]    mm_b;
    logic [PW-1:0]   mm_x;
    logic [PW+W:0]   mm_xmu;
    logic [W:0]      mm_t;
    logic [PW-1:0]   mm_tq;
    logic [W+1:0]    mm_r0;
    logic [W+1:0]    mm_r1;
    logic [W+1:0]    mm_r2;
    logic [W-1:0]    mm_r;

    // 4095 < 2Q, so a single conditional subtract canonicalises the operand
    assign base_in = (din_a >= Q_W) ? din_a - Q_W : din_a;

    // Barrett reduction: the quotient estimate is low by at most 2, so r < 3Q
    assign mm_b   = (state == MUL) ? base : acc;
    assign mm_x   = acc * mm_b;
    assign mm_xmu = mm_x * MU_W;
    assign mm_t   = (W + 1)'(mm_xmu >> PW);
    assign mm_tq  = mm_t * Q_W;
    assign mm_r0  = (W + 2)'(mm_x - mm_tq);
    assign mm_r1  = (mm_r0 >= Q_R) ? mm_r0 - Q_R : mm_r0;
    assign mm_r2  = (mm_r1 >= Q_R) ? mm_r1 - Q_R : mm_r1;
    assign mm_r   = W'(mm_r2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SQR;
            end
            SQR: begin
                if (EXP_W[idx])    state_nxt = MUL;
                else if (idx == '0) state_nxt = DONE;
            end
            MUL: begin
                state_nxt = (idx == '0) ? DONE : SQR;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            base   <= '0;
            idx    <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base   <= base_in;
                        acc    <= base_in;
                        idx    <= IW'(W - 2);
                        zero_q <= (base_in == '0);
                    end
                end
                SQR: begin
                    acc <= mm_r;
                    if (!EXP_W[idx] && idx != '0) idx <= idx - 1'b1;
                end
                MUL: begin
                    acc <= mm_r;
                    if (idx != '0) idx <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout_r   = acc;
    assign zero_err = zero_q;

endmodule

// File: tb/tb_modinv_fermat_4049.sv
// tb/tb_modinv_fermat_4049.sv - scoreboard bench for modinv_fermat_4049
module tb_modinv_fermat_4049;
    localparam int Q   = 4049;
    localparam int LAT = 20;

    logic        clk;
    logic        rst;
    logic [11:0] din_a;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dout_r;
    logic        zero_err;
    logic        out_valid;
    logic        out_ready;

    modinv_fermat_4049 dut (
        .clk       (clk),
        .rst       (rst),
        .din_a     (din_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout_r    (dout_r),
        .zero_err  (zero_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int inv;
        bit zero;
    } exp_t;

    exp_t sb[$];
    int   op_q[$];
    int   n_pass;
    int   n_total;
    int   cyc;
    bit   busy;
    int   cnt;

    task automatic check(input string tag, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    endtask

    // extended Euclid, independent of the exponentiation the design uses
    function automatic int inv_model(input int a);
        int r0 = Q;
        int r1 = a % Q;
        int t0 = 0;
        int t1 = 1;
        int q;
        int tmp;
        if (r1 == 0) return 0;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = t0 - q * t1;
            t0  = t1;
            t1  = tmp;
        end
        if (t0 < 0) t0 += Q;
        return t0;
    endfunction

    task automatic run_ops(input int in_pct, input int rdy_pct, input bit b2b);
        int   budget;
        int   last_acc;
        int   n;
        exp_t e;
        budget   = op_q.size() * 60 + 100;
        last_acc = -1;
        n        = 0;
        while (op_q.size() != 0 || busy) begin
            @(negedge clk);
            cyc++;
            n++;
            if (n > budget) begin
                check("timeout", 0, 1);
                break;
            end
            check("in_ready", int'(in_ready), int'(!busy));
            check("out_valid", int'(out_valid), int'(busy && cnt >= LAT));
            if (busy && cnt >= LAT && sb.size() != 0) begin
                check("dout_r", int'(dout_r), sb[0].inv);
                check("zero_err", int'(zero_err), int'(sb[0].zero));
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = (op_q.size() != 0) && ($urandom_range(99) < in_pct);
            din_a     = in_valid ? 12'(op_q[0]) : 12'($urandom);
            if (!busy) begin
                if (in_valid) begin
                    e.a    = op_q.pop_front();
                    e.inv  = inv_model(e.a);
                    e.zero = (e.a % Q == 0);
                    sb.push_back(e);
                    busy = 1'b1;
                    cnt  = 0;
                    if (b2b && last_acc >= 0) check("spacing", cyc - last_acc, 22);
                    last_acc = cyc;
                end
            end else if (cnt < LAT) begin
                cnt++;
            end else if (out_ready) begin
                e = sb.pop_front();
                if (!e.zero) check("a_times_inv", (e.a * int'(dout_r)) % Q, 1);
                busy = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        busy      = 1'b0;
        cnt       = 0;
        rst       = 1'b1;
        din_a     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dout_r", int'(dout_r), 0);
        check("rst_zero_err", int'(zero_err), 0);

        // directed values, back-to-back with out_ready held high
        op_q = '{1, 2, 3, 4048, 4050, 0, 4049};
        run_ops(100, 100, 1'b1);

        // asynchronous reset in the middle of the square/multiply loop
        @(negedge clk);
        din_a    = 12'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_dout_r", int'(dout_r), 0);
        check("midrst_zero_err", int'(zero_err), 0);
        @(negedge clk);
        rst  = 1'b0;
        busy = 1'b0;
        sb.delete();
        op_q = '{2};
        run_ops(100, 100, 1'b0);

        // random operands with input gaps and output stalls
        op_q = '{4048, 1, 4095, 4050};
        for (int i = 0; i < 1000; i++) op_q.push_back($urandom_range(4048, 1));
        run_ops(60, 60, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
